key_debouncer: RTL and testbench

- Conditions the raw push-button inputs of the piano before they reach the key encoder.
- Synchronises each key, debounces it against a millisecond-scale stability window, and produces a clean key vector.
- Also produces one-cycle press/release event pulses and a "current key" index with valid flag.
- Runs on the 5 MHz divided clock. Its clean vector drives the encoder's key input.

---
 rtl/key_debouncer.sv | 250 +++++++++++++++++++++++++
 tb/tb_key_debouncer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
//
// Conditions the raw push-button inputs of the piano before they reach the key
// encoder. Each key is synchronised, then debounced against a stability window
// of STABLE_TICKS consecutive debounce ticks (one tick every TICK_DIV cycles).
// A clean key vector, one-cycle press/release pulses, a "current key" index
// with a valid flag, and an any-key-held flag are produced.
//
// Parameters:
//   NUM_KEYS     number of key inputs
//   IDX_W        width of cur_key; 2**IDX_W must cover NUM_KEYS
//   TICK_DIV     clock cycles per debounce tick (>= 2)
//   STABLE_TICKS ticks a new level must persist before acceptance (>= 1)
//
// Ports:
//   clk_in        block clock (5 MHz domain)
//   reset         synchronous active-high reset
//   keys_raw      asynchronous raw key levels, 1 = pressed
//   keys_clean    debounced key levels
//   press_pulse   one-cycle pulse, cycle after a clean 0->1 transition
//   release_pulse one-cycle pulse, cycle after a clean 1->0 transition
//   cur_key       index of the current key
//   key_valid     cur_key refers to a held key
//   any_pressed   registered OR of keys_clean
// -----------------------------------------------------------------------------
module key_debouncer #(
  parameter int NUM_KEYS     = 10,
  parameter int IDX_W        = 4,
  parameter int TICK_DIV     = 5000,
  parameter int STABLE_TICKS = 8
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys_raw,
  output logic [NUM_KEYS-1:0] keys_clean,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [IDX_W-1:0]    cur_key,
  output logic                key_valid,
  output logic                any_pressed
);

  // Tick counter spans 0..TICK_DIV-1.
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // One spare bit so the count can reach STABLE_TICKS-1 without ever wrapping.
  localparam int CNT_W  = $clog2(STABLE_TICKS) + 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_TICKS - 1);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Lowest set index of a key vector; 0 when the vector is empty.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_KEYS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      idx = v[i] ? IDX_W'(i) : idx;
    end
    return idx;
  endfunction

  // True when bit 'idx' of the vector is set. Written as a scan so an index
  // beyond NUM_KEYS simply yields 0 instead of an out-of-range select.
  function automatic logic key_hit(input logic [NUM_KEYS-1:0] v,
                                   input logic [IDX_W-1:0]    idx);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      hit = hit | (v[i] & (IDX_W'(i) == idx));
    end
    return hit;
  endfunction

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] sync1_r;
  logic [NUM_KEYS-1:0] ksync_r;

  logic [TICK_W-1:0]   tick_cnt_r;
  logic                tick_s;

  logic [CNT_W-1:0]    cnt_r     [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_nxt_s [NUM_KEYS];
  logic [NUM_KEYS-1:0] clean_r;
  logic [NUM_KEYS-1:0] clean_nxt_s;
  logic [NUM_KEYS-1:0] clean_prev_r;

  logic [NUM_KEYS-1:0] press_ev_s;
  logic [NUM_KEYS-1:0] rel_ev_s;
  logic [NUM_KEYS-1:0] press_r;
  logic [NUM_KEYS-1:0] release_r;
  logic                any_r;

  logic [IDX_W-1:0]    cur_r;
  logic [IDX_W-1:0]    cur_nxt_s;
  logic                valid_r;
  logic                valid_nxt_s;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser; only the second stage feeds the debounce logic.
  // ---------------------------------------------------------------------------

  // Synchroniser flops for the asynchronous key inputs.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync1_r <= '0;
      ksync_r <= '0;
    end else begin
      sync1_r <= keys_raw;
      ksync_r <= sync1_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce tick generator
  // ---------------------------------------------------------------------------
  assign tick_s = (tick_cnt_r == TICK_LAST);

  // Free-running tick divider, wraps to 0 on the tick cycle.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      tick_cnt_r <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_W'(1'b1);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-key stability window
  //
  // Agreement between ksync and the clean level clears the window immediately,
  // so any bounce back restarts it. Disagreement only advances on tick cycles;
  // the STABLE_TICKS-th consecutive tick accepts the new level.
  // ---------------------------------------------------------------------------

  // Next-state logic for the stability counters and the clean levels.
  always_comb begin
    clean_nxt_s = clean_r;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      if (ksync_r[i] == clean_r[i]) begin
        cnt_nxt_s[i] = '0;
      end else if (tick_s) begin
        if (cnt_r[i] == CNT_LAST) begin
          clean_nxt_s[i] = ksync_r[i];
          cnt_nxt_s[i]   = '0;
        end else begin
          cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1'b1);
        end
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end
    end
  end

  // Stability counters and clean key levels.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt_r[i] <= '0;
      end
      clean_r <= '0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      clean_r <= clean_nxt_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Edge events
  //
  // Edges are detected against the previous clean vector, so the registered
  // pulses land one cycle after keys_clean changes, together with the
  // cur_key / key_valid / any_pressed updates.
  // ---------------------------------------------------------------------------
  assign press_ev_s = clean_r & ~clean_prev_r;
  assign rel_ev_s   = ~clean_r & clean_prev_r;

  // Previous clean vector, event pulses and any-key flag.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      clean_prev_r <= '0;
      press_r      <= '0;
      release_r    <= '0;
      any_r        <= 1'b0;
    end else begin
      clean_prev_r <= clean_r;
      press_r      <= press_ev_s;
      release_r    <= rel_ev_s;
      any_r        <= |clean_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Current-key tracking
  //
  // A press always takes priority, even when cur_key releases in the same
  // cycle. Releasing the current key falls back to the lowest key still held.
  // ---------------------------------------------------------------------------

  // Next current-key index and valid flag.
  always_comb begin
    cur_nxt_s   = cur_r;
    valid_nxt_s = valid_r;
    if (|press_ev_s) begin
      cur_nxt_s   = lowest_idx(press_ev_s);
      valid_nxt_s = 1'b1;
    end else if (key_hit(rel_ev_s, cur_r)) begin
      if (|clean_r) begin
        cur_nxt_s   = lowest_idx(clean_r);
        valid_nxt_s = 1'b1;
      end else begin
        cur_nxt_s   = '0;
        valid_nxt_s = 1'b0;
      end
    end else begin
      cur_nxt_s   = cur_r;
      valid_nxt_s = valid_r;
    end
  end

  // Current-key registers.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cur_r   <= '0;
      valid_r <= 1'b0;
    end else begin
      cur_r   <= cur_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all registered)
  // ---------------------------------------------------------------------------
  assign keys_clean    = clean_r;
  assign press_pulse   = press_r;
  assign release_pulse = release_r;
  assign cur_key       = cur_r;
  assign key_valid     = valid_r;
  assign any_pressed   = any_r;

endmodule

// File: tb/tb_key_debouncer.sv
// -----------------------------------------------------------------------------
// tb_key_debouncer
//
// Directed bench for key_debouncer with TICK_DIV=4, STABLE_TICKS=3. Stimulus
// pushes the expected event record (pulses, cur_key, key_valid, any_pressed,
// keys_clean) before changing keys_raw; a monitor pops and compares on every
// cycle in which the DUT shows a press or release pulse.
// -----------------------------------------------------------------------------
module tb_key_debouncer;

  localparam int NK = 10;
  localparam int IW = 4;
  localparam int TD = 4;
  localparam int ST = 3;

  logic          clk_in = 1'b0;
  logic          reset;
  logic [NK-1:0] keys_raw;
  logic [NK-1:0] keys_clean;
  logic [NK-1:0] press_pulse;
  logic [NK-1:0] release_pulse;
  logic [IW-1:0] cur_key;
  logic          key_valid;
  logic          any_pressed;

  typedef struct packed {
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
    logic [IW-1:0] cur;
    logic          valid;
    logic          any;
    logic [NK-1:0] clean;
  } ev_t;

  ev_t exp_q[$];
  int  pass_cnt  = 0;
  int  total_cnt = 0;

  always #5 clk_in = ~clk_in;

  key_debouncer #(
    .NUM_KEYS    (NK),
    .IDX_W       (IW),
    .TICK_DIV    (TD),
    .STABLE_TICKS(ST)
  ) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .keys_raw     (keys_raw),
    .keys_clean   (keys_clean),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .cur_key      (cur_key),
    .key_valid    (key_valid),
    .any_pressed  (any_pressed)
  );

  function automatic ev_t mk(input logic [NK-1:0] p, input logic [NK-1:0] r,
                             input logic [IW-1:0] c, input logic v,
                             input logic a, input logic [NK-1:0] cl);
    ev_t e;
    e.press = p;
    e.rel   = r;
    e.cur   = c;
    e.valid = v;
    e.any   = a;
    e.clean = cl;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total_cnt++;
    if (act >= lo && act <= hi) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Counts rising edges until keys_clean[k] reaches val (bounded at 40).
  task automatic wait_clean(input int k, input logic val, output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk_in);
      n++;
      #1;
      if (keys_clean[k] === val) break;
    end
  endtask

  // Drives the masked keys to val, expects one event, checks the latency.
  task automatic step_keys(input logic [NK-1:0] mask, input logic val, input int watch,
                           input ev_t e, input string name);
    int n;
    exp_q.push_back(e);
    keys_raw = val ? (keys_raw | mask) : (keys_raw & ~mask);
    wait_clean(watch, val, n);
    check_range(name, n, 11, 14);
    @(negedge clk_in);
    cycles(3);
  endtask

  // Monitor: every cycle with a pulse must match the next expected event.
  initial begin
    ev_t got;
    ev_t want;
    forever begin
      @(negedge clk_in);
      if (reset === 1'b0 && (press_pulse !== '0 || release_pulse !== '0)) begin
        got = mk(press_pulse, release_pulse, cur_key, key_valid, any_pressed, keys_clean);
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_event: press=%b release=%b clean=%b, no event expected",
                   got.press, got.rel, got.clean);
        end else begin
          want = exp_q.pop_front();
          if (got === want) pass_cnt++;
          else $display("FAIL event: got press=%b rel=%b cur=%0d valid=%b any=%b clean=%b, expected press=%b rel=%b cur=%0d valid=%b any=%b clean=%b",
                        got.press, got.rel, got.cur, got.valid, got.any, got.clean,
                        want.press, want.rel, want.cur, want.valid, want.any, want.clean);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    keys_raw = '0;
    cycles(3);
    reset = 1'b0;
    check("reset_outputs", int'({keys_clean, press_pulse, release_pulse, cur_key, key_valid, any_pressed}), 0);

    // Idle: nothing may change with all keys released.
    for (int c = 0; c < 50; c++) begin
      @(negedge clk_in);
      check("idle_outputs", int'({keys_clean, press_pulse, release_pulse, cur_key, key_valid, any_pressed}), 0);
    end

    // Single press of key 3.
    step_keys(10'h008, 1'b1, 3, mk(10'h008, 10'h000, 4'd3, 1'b1, 1'b1, 10'h008), "key3_press_latency");
    check("key3_cur", int'(cur_key), 3);
    check("key3_valid", int'(key_valid), 1);
    check("key3_any", int'(any_pressed), 1);

    // Bouncing key 5: 6-cycle highs never survive three ticks.
    for (int h = 0; h < 10; h++) begin
      keys_raw[5] = (h % 2 == 0) ? 1'b1 : 1'b0;
      cycles(6);
    end
    check("key5_bounce_clean", int'(keys_clean[5]), 0);
    step_keys(10'h020, 1'b1, 5, mk(10'h020, 10'h000, 4'd5, 1'b1, 1'b1, 10'h028), "key5_settle_latency");

    // Release 3 (not current) then 5 (current, last held).
    step_keys(10'h008, 1'b0, 3, mk(10'h000, 10'h008, 4'd5, 1'b1, 1'b1, 10'h020), "key3_release_latency");
    check("key3_rel_cur", int'(cur_key), 5);
    step_keys(10'h020, 1'b0, 5, mk(10'h000, 10'h020, 4'd0, 1'b0, 1'b0, 10'h000), "key5_release_latency");

    // Keys 7 and 2 together; lowest newly pressed wins.
    step_keys(10'h084, 1'b1, 2, mk(10'h084, 10'h000, 4'd2, 1'b1, 1'b1, 10'h084), "keys27_press_latency");
    check("keys27_clean", int'(keys_clean), 'h084);
    check("keys27_cur", int'(cur_key), 2);
    step_keys(10'h004, 1'b0, 2, mk(10'h000, 10'h004, 4'd7, 1'b1, 1'b1, 10'h080), "key2_release_latency");
    check("key2_rel_cur", int'(cur_key), 7);
    check("key2_rel_valid", int'(key_valid), 1);
    step_keys(10'h080, 1'b0, 7, mk(10'h000, 10'h080, 4'd0, 1'b0, 1'b0, 10'h000), "key7_release_latency");
    check("key7_rel_valid", int'(key_valid), 0);
    check("key7_rel_cur", int'(cur_key), 0);

    // Key 4 held, key 9 pressed, then released in order 4, 9.
    step_keys(10'h010, 1'b1, 4, mk(10'h010, 10'h000, 4'd4, 1'b1, 1'b1, 10'h010), "key4_press_latency");
    step_keys(10'h200, 1'b1, 9, mk(10'h200, 10'h000, 4'd9, 1'b1, 1'b1, 10'h210), "key9_press_latency");
    check("key9_cur", int'(cur_key), 9);
    step_keys(10'h010, 1'b0, 4, mk(10'h000, 10'h010, 4'd9, 1'b1, 1'b1, 10'h200), "key4_release_latency");
    check("key4_rel_cur", int'(cur_key), 9);
    step_keys(10'h200, 1'b0, 9, mk(10'h000, 10'h200, 4'd0, 1'b0, 1'b0, 10'h000), "key9_release_latency");
    check("key9_rel_valid", int'(key_valid), 0);

    // Reset in the middle of key 1's window discards the partial count.
    keys_raw[1] = 1'b1;
    cycles(6);
    check("key1_midwindow_clean", int'(keys_clean[1]), 0);
    reset = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    check("midreset_outputs", int'({keys_clean, press_pulse, release_pulse, cur_key, key_valid, any_pressed}), 0);
    begin
      int n;
      exp_q.push_back(mk(10'h002, 10'h000, 4'd1, 1'b1, 1'b1, 10'h002));
      wait_clean(1, 1'b1, n);
      check_range("key1_full_window_after_reset", n, 11, 14);
      @(negedge clk_in);
      cycles(3);
    end
    step_keys(10'h002, 1'b0, 1, mk(10'h000, 10'h002, 4'd0, 1'b0, 1'b0, 10'h000), "key1_release_latency");

    cycles(10);
    check("events_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
